// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the 2-input gate stimulus/response engine.
package gate_test_pkg;

  // Run-control states of the tester.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Expected truth tables, bit index = {a,b}.
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_NOR  = 4'b0001;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;

  // Next input vector in the 00,01,10,11 sweep order (wraps modulo 4).
  function automatic logic [1:0] vec_next(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/gate_tester_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, increment unless already all-ones, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gate_tester.sv
// Drives all four input vectors into a 2-input gate, samples its output after
// HOLD cycles per vector, and compares against TRUTH for PASSES sweeps.
module gate_tester
  import gate_test_pkg::*;
#(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         HOLD   = 2,
  parameter int         PASSES = 1,
  parameter int         ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec,
  output logic             fail_seen
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  state_e          state_q, state_d;
  logic [1:0]      vec_q, vec_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [PW-1:0]   pidx_q, pidx_d;
  logic            a_q, a_d, b_q, b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [1:0]      fvec_q, fvec_d;
  logic            fseen_q, fseen_d;

  logic             sample_s;
  logic             mismatch_s;
  logic             last_s;
  logic [1:0]       vec_inc_s;
  logic             err_clr_s;
  logic             err_inc_s;
  logic [ERR_W-1:0] err_count_s;

  // A compare happens on the last cycle of each vector's hold window.
  assign sample_s   = (state_q == ST_APPLY) && (hold_q == HOLD_LAST);
  assign mismatch_s = sample_s && (dut_c != TRUTH[vec_q]);
  assign last_s     = sample_s && (vec_q == 2'd3) && (pidx_q == PASS_LAST);
  assign vec_inc_s  = vec_next(vec_q);

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (err_clr_s),
    .inc_i   (err_inc_s),
    .count_o (err_count_s)
  );

  // Next-state, stimulus and result logic of the run controller.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    pidx_d    = pidx_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fvec_d    = fvec_q;
    fseen_d   = fseen_q;
    err_clr_s = 1'b0;
    err_inc_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_APPLY;
          vec_d     = 2'd0;
          a_d       = 1'b0;
          b_d       = 1'b0;
          hold_d    = {HW{1'b0}};
          pidx_d    = {PW{1'b0}};
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fvec_d    = 2'd0;
          fseen_d   = 1'b0;
          err_clr_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        err_inc_s = mismatch_s;
        // Only the first mismatch of a run records its vector.
        if (mismatch_s && !fseen_q) begin
          fseen_d = 1'b1;
          fvec_d  = vec_q;
        end else begin
          fseen_d = fseen_q;
        end
        if (sample_s) begin
          hold_d = {HW{1'b0}};
          vec_d  = vec_inc_s;
          a_d    = vec_inc_s[1];
          b_d    = vec_inc_s[0];
          if (vec_q == 2'd3) begin
            pidx_d = pidx_q + PW'(1);
          end else begin
            pidx_d = pidx_q;
          end
          if (last_s) begin
            state_d = ST_DONE;
            vec_d   = 2'd0;
            pidx_d  = {PW{1'b0}};
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Includes this final compare: next count is zero only if
            // the count is zero now and this sample matched.
            pass_d  = (err_count_s == {ERR_W{1'b0}}) && !mismatch_s;
          end else begin
            state_d = ST_APPLY;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      hold_q  <= {HW{1'b0}};
      pidx_q  <= {PW{1'b0}};
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fvec_q  <= 2'd0;
      fseen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      pidx_q  <= pidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fvec_q  <= fvec_d;
      fseen_q <= fseen_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_s;
  assign fail_vec  = fvec_q;
  assign fail_seen = fseen_q;

endmodule

// File: doc/gate_tester.md
Name: gate_tester

Overview:
- Self-checking stimulus/response engine for 2-input combinational gate primitives.
- Sits on the opposite side of a gate's a/b/c interface: drives dut_a/dut_b, samples dut_c, compares against an expected truth table.
- Used in on-board bring-up and the regression top level. It sweeps all four input vectors for a programmable number of passes and reports pass/fail, an error count and the first failing vector.

Parameters:
- TRUTH, 4'b1000, expected output per vector; bit index = {dut_a,dut_b} (4'b1000 = AND).
- HOLD, 2, cycles each vector is held before sampling; legal values >= 1.
- PASSES, 1, number of full 4-vector sweeps per run; legal values >= 1.
- ERR_W, 4, width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- dut_a  output  1  stimulus to gate input a, registered.
- dut_b  output  1  stimulus to gate input b, registered.
- dut_c  input  1  gate output under test.
- busy  output  1  sweep in progress.
- done  output  1  run complete; level, held until next start.
- pass  output  1  valid with done; 1 when err_count == 0.
- err_count  output  ERR_W  saturating mismatch count for the current or last run.
- fail_vec  output  2  {a,b} of the first mismatch; valid when fail_seen = 1.
- fail_seen  output  1  at least one mismatch in the current or last run.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: dut_a = dut_b = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 0, fail_seen = 0. FSM enters IDLE.
- FSM states IDLE, APPLY, DONE:
  - IDLE -> APPLY on start = 1.
  - APPLY -> DONE after the final sample.
  - DONE -> APPLY on start = 1.
- Entering APPLY (edge E0 that samples start = 1):
  - vec = 0 drives dut_a = vec[1], dut_b = vec[0].
  - busy = 1; done = 0; pass = 0; err_count = 0; fail_seen = 0; fail_vec = 0; hold_cnt = 0; pass_idx = 0.
- APPLY:
  - hold_cnt increments each cycle.
  - At the edge where hold_cnt == HOLD-1, dut_c is sampled and compared to TRUTH[vec]. At that same edge hold_cnt returns to 0 and vec increments modulo 4; the new stimulus appears at that edge.
  - vec wrapping 3 -> 0 increments pass_idx.
- Mismatch:
  - err_count increments, saturating at 2^ERR_W-1 with no wrap.
  - The first mismatch of a run latches fail_vec = vec and sets fail_seen. Later mismatches do not overwrite fail_vec.
- Final sample (vec == 3, pass_idx == PASSES-1), at edge E0 + 4*HOLD*PASSES:
  - busy = 0, done = 1, dut_a = dut_b = 0.
  - pass = (err_count_next == 0), so the last compare is included.
- Simultaneous start and final sample cannot occur, because start is ignored in APPLY.
- start while busy: ignored; no restart, no counter disturbance.
- start in DONE: restarts at that edge; done and pass drop at the same edge.
- rst_n asserted mid-sweep: immediate return to reset values. Partial results are discarded and no done pulse is produced.
- dut_c is sampled directly. The DUT is combinational from registered stimulus, so HOLD >= 1 guarantees one full cycle of settling.

Decomposition:
- Package gate_test_pkg:
  - state enum (IDLE, APPLY, DONE).
  - Truth constants TRUTH_AND = 4'b1000, TRUTH_OR = 4'b1110, TRUTH_NAND = 4'b0111, TRUTH_NOR = 4'b0001, TRUTH_XOR = 4'b0110.
- Sub-module sat_counter: parameterised width; clear, increment and saturate. Used for err_count.

Test Plan:
- AND DUT, TRUTH = AND, HOLD = 2, PASSES = 1: pulse start -> dut_a/dut_b = 00, 01, 10, 11, each for 2 cycles. busy is high for 8 cycles; done = 1 and pass = 1 at E0+8; err_count = 0; fail_seen = 0.
- dut_c tied 0, TRUTH = AND -> err_count = 1, fail_vec = 2'b11, fail_seen = 1, pass = 0.
- dut_c tied 1, TRUTH = AND, PASSES = 8, ERR_W = 2 -> 24 mismatches; err_count saturates at 3; fail_vec = 2'b00.
- AND DUT: assert start repeatedly while busy -> sweep completes exactly at E0+8. Then start in DONE -> done drops at that edge and the next done arrives 8 cycles later.
- XOR DUT, HOLD = 3, PASSES = 2: pulse rst_n low at cycle 5 -> all outputs return to reset values immediately and stay in IDLE. A fresh start then yields done at E0+24 with pass = 1.
